soc_system_lt24_adc_busy_cond: RTL

//   Upstream conditioner for the LT24 touch-ADC BUSY pad. Synchronises and glitch-filters the raw pad,

---
 rtl/soc_system_lt24_adc_busy_cond.sv | 114 +++++++++++
 1 files changed

// File: rtl/soc_system_lt24_adc_busy_cond.sv
// Conditioner for the LT24 touch-ADC BUSY pad: synchroniser, glitch filter, done/timeout capture,
// busy-duration measurement and a small Avalon-MM register slave with a level IRQ.
module soc_system_lt24_adc_busy_cond #(
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        adc_busy_pad,
   output logic        busy_filt,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             s1, s2;
   logic             busy_q;
   logic [7:0]       fcnt;
   logic [CNT_W-1:0] dcnt;
   logic [CNT_W-1:0] last_len;
   logic [1:0]       mask;
   logic [1:0]       capture;
   logic [1:0]       capture_next;
   logic [1:0]       cap_clr;
   logic [31:0]      rd_mux;
   logic             fall;
   logic             timeout_hit;
   logic             wr_en;
   logic             rd_en;
   wire              unused_wdata = ^writedata[31:2];

   assign wr_en       = chipselect & ~write_n;
   assign rd_en       = chipselect & write_n;
   assign fall        = busy_q & ~busy_filt;
   assign timeout_hit = busy_filt && (dcnt == TO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         busy_filt <= 1'b0;
         busy_q    <= 1'b0;
         fcnt      <= 8'd0;
      end else begin
         s1     <= adc_busy_pad;
         s2     <= s1;
         busy_q <= busy_filt;
         // A pending level change survives only while s2 keeps disagreeing for FILTER_LEN samples
         if (s2 == busy_filt) begin
            fcnt <= 8'd0;
         end else if (fcnt == FILT_LAST) begin
            busy_filt <= s2;
            fcnt      <= 8'd0;
         end else begin
            fcnt <= fcnt + 8'd1;
         end
      end
   end

   // Falling edge is seen one cycle after busy_filt drops, so dcnt already holds the full length
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dcnt     <= '0;
         last_len <= '0;
      end else begin
         if (busy_filt) begin
            if (dcnt != '1) dcnt <= dcnt + CNT_ONE;
         end else begin
            dcnt <= '0;
         end
         if (fall) last_len <= dcnt;
      end
   end

   always_comb begin
      cap_clr      = 2'b00;
      if (wr_en && address == 2'd2) cap_clr = writedata[1:0];
      capture_next = (capture & ~cap_clr) | {timeout_hit, fall};
   end

   always_comb begin
      rd_mux = 32'd0;
      case (address)
         2'd0: rd_mux = {31'd0, busy_filt};
         2'd1: rd_mux = {30'd0, mask};
         2'd2: rd_mux = {30'd0, capture};
         2'd3: rd_mux = 32'(last_len);
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask     <= 2'b00;
         capture  <= 2'b00;
         readdata <= 32'd0;
         irq      <= 1'b0;
      end else begin
         if (wr_en && address == 2'd1) mask <= writedata[1:0];
         capture  <= capture_next;
         readdata <= rd_en ? rd_mux : 32'd0;
         irq      <= |(capture & mask);
      end
   end

endmodule
